imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction and immediate width.
REQ-002 The block SHALL have parameter J_IMM_W, default 28, meaning the immediate field width for opcode J (4'b1000).
REQ-003 The block SHALL have parameter LI_IMM_W, default 23, meaning the immediate field width for opcode LI (4'b0010).
REQ-004 The block SHALL have parameter DEF_IMM_W, default 18, meaning the immediate field width for all other opcodes.
REQ-005 The block SHALL have parameter DEPTH, default 2, meaning the output buffer entries (power of two, >=2).
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-008 The block SHALL have port IR_i, input, DATA_W bits, the instruction word; opcode is IR_i[DATA_W-1:DATA_W-4].
REQ-009 The block SHALL have port valid_i, input, 1 bit, meaning IR_i and zext_i are offered.
REQ-010 The block SHALL have port zext_i, input, 1 bit, meaning zero-extend instead of sign-extend.
REQ-011 The block SHALL have port ready_o, output, 1 bit, meaning an entry is free.
REQ-012 The block SHALL have port data_o, output, DATA_W bits, the extended immediate at buffer head.
REQ-013 The block SHALL have port kind_o, output, 2 bits, the head format: 00 default, 01 LI, 10 J.
REQ-014 The block SHALL have port valid_o, output, 1 bit, meaning data_o/kind_o are valid.
REQ-015 The block SHALL have port ready_i, input, 1 bit, meaning the consumer takes the head.

Function
REQ-016 An input transfer SHALL occur on a rising edge with valid_i=1 and ready_o=1; an output transfer SHALL occur with valid_o=1 and ready_i=1.
REQ-017 Extraction SHALL take the low J_IMM_W, LI_IMM_W or DEF_IMM_W bits of IR_i by opcode and fill the upper bits with the field MSB, or with 0 when zext_i=1.
REQ-018 The extended value and kind SHALL be computed at input transfer time and stored; later IR_i/zext_i changes SHALL NOT affect stored entries.
REQ-019 Latency SHALL be one cycle: a word accepted at edge N into an empty buffer SHALL show valid_o=1 after edge N.
REQ-020 The buffer SHALL be FIFO-ordered, with read/write pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-021 ready_o SHALL be 1 exactly when occupancy < DEPTH and SHALL depend only on registered state.
REQ-022 valid_o SHALL be 1 exactly when occupancy > 0.
REQ-023 On simultaneous input and output transfer, occupancy SHALL remain unchanged and both pointers SHALL advance.
REQ-024 When full, valid_i SHALL be ignored, even if ready_i=1 in the same cycle.
REQ-025 When valid_o=0, data_o and kind_o SHALL be 0.

Reset
REQ-026 With rst_i=1 at an edge, pointers and occupancy SHALL clear to 0, so that ready_o=1, valid_o=0, data_o=0 and kind_o=0 after that edge.
REQ-027 A reset during traffic SHALL discard all buffered entries and SHALL ignore any transfer in that cycle.

Configuration
REQ-028 With macro IMM_GEN_PIPE_STATS_EN defined, the block SHALL add output count_o (16 bits, reset 0) that increments by 1 per output transfer and wraps 0xFFFF->0; without the macro, count_o and its logic SHALL be absent.

Verification
REQ-029 Defaults, IR_i=0x88000001 (J), zext_i=0, ready_i=1 -> next cycle data_o=0xF8000001, kind_o=10, valid_o=1.
REQ-030 IR_i=0x20400005 (LI), zext_i=0 -> data_o=0xFFC00005, kind_o=01.
REQ-031 IR_i=0x40020003, zext_i=0 -> data_o=0xFFFE0003; same IR_i with zext_i=1 -> data_o=0x00020003, kind_o=00.
REQ-032 ready_i=0, push 0x40000001 then 0x40000002 -> ready_o=0 after 2nd edge; 3rd push ignored; then ready_i=1 -> outputs 0x00000001, 0x00000002 in order, then valid_o=0.
REQ-033 Buffer holding 2 entries, assert rst_i for one edge with valid_i=1 -> valid_o=0, ready_o=1, data_o=0 next cycle; nothing delivered.
REQ-034 With IMM_GEN_PIPE_STATS_EN, 3 output transfers -> count_o=3; preset count_o to 0xFFFF and do 1 transfer -> count_o=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate extractor with a small output FIFO.
//
// Decodes the opcode in IR_i[DATA_W-1:DATA_W-4] and picks a field width:
//   opcode 4'b1000 (J)  -> J_IMM_W bits,  kind 2'b10
//   opcode 4'b0010 (LI) -> LI_IMM_W bits, kind 2'b01
//   any other opcode    -> DEF_IMM_W bits, kind 2'b00
// The field is sign-extended to DATA_W, or zero-extended when zext_i=1.
// The result is computed when the word is accepted and is queued in a
// DEPTH-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset
//   IR_i     in   instruction word
//   valid_i  in   IR_i/zext_i offered
//   zext_i   in   zero-extend instead of sign-extend
//   ready_o  out  a FIFO entry is free
//   data_o   out  extended immediate at FIFO head (0 when empty)
//   kind_o   out  format of head entry (0 when empty)
//   valid_o  out  data_o/kind_o valid
//   ready_i  in   consumer takes the head
//   count_o  out  16-bit output-transfer counter, wraps
//                 (present only when IMM_GEN_PIPE_STATS_EN is defined)
//
// Build option: define IMM_GEN_PIPE_STATS_EN to add count_o.

module imm_gen_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned J_IMM_W   = 28,
  parameter int unsigned LI_IMM_W  = 23,
  parameter int unsigned DEF_IMM_W = 18,
  parameter int unsigned DEPTH     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] IR_i,
  input  logic              valid_i,
  input  logic              zext_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        kind_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef IMM_GEN_PIPE_STATS_EN
  ,
  output logic [15:0]       count_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_J  = 4'b1000;
  localparam logic [3:0] OP_LI = 4'b0010;

  localparam logic [1:0] KIND_DEF = 2'b00;
  localparam logic [1:0] KIND_LI  = 2'b01;
  localparam logic [1:0] KIND_J   = 2'b10;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Extraction
  logic [3:0]        w_opcode;
  logic              w_j_fill;
  logic              w_li_fill;
  logic              w_def_fill;
  logic [DATA_W-1:0] w_ext_j;
  logic [DATA_W-1:0] w_ext_li;
  logic [DATA_W-1:0] w_ext_def;
  logic [DATA_W-1:0] w_ext;
  logic [1:0]        w_kind;

  assign w_opcode   = IR_i[DATA_W-1 -: 4];
  // Fill bit is the field MSB, forced to 0 for zero-extension.
  assign w_j_fill   = IR_i[J_IMM_W-1]   & ~zext_i;
  assign w_li_fill  = IR_i[LI_IMM_W-1]  & ~zext_i;
  assign w_def_fill = IR_i[DEF_IMM_W-1] & ~zext_i;

  assign w_ext_j   = {{(DATA_W - J_IMM_W){w_j_fill}},     IR_i[J_IMM_W-1:0]};
  assign w_ext_li  = {{(DATA_W - LI_IMM_W){w_li_fill}},   IR_i[LI_IMM_W-1:0]};
  assign w_ext_def = {{(DATA_W - DEF_IMM_W){w_def_fill}}, IR_i[DEF_IMM_W-1:0]};

  always_comb begin
    w_ext  = w_ext_def;
    w_kind = KIND_DEF;
    case (w_opcode)
      OP_J: begin
        w_ext  = w_ext_j;
        w_kind = KIND_J;
      end
      OP_LI: begin
        w_ext  = w_ext_li;
        w_kind = KIND_LI;
      end
      default: begin
        w_ext  = w_ext_def;
        w_kind = KIND_DEF;
      end
    endcase
  end

  // FIFO
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [1:0]        r_kind_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // ready_o comes from registered occupancy only, so a full FIFO refuses
  // input even if the head is being taken in the same cycle.
  assign ready_o = (r_count < FULL_CNT);
  assign valid_o = (r_count != '0);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  assign data_o = valid_o ? r_data_mem[r_rptr] : '0;
  assign kind_o = valid_o ? r_kind_mem[r_rptr] : 2'b00;

  // Storage needs no reset: contents are masked while occupancy is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_data_mem[r_wptr] <= w_ext;
      r_kind_mem[r_wptr] <= w_kind;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IMM_GEN_PIPE_STATS_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xfer_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 16'h0001;
    end
  end

  assign count_o = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vectors, scoreboard queue filled by the
// driver at accept time, drained by a monitor on output transfers.

module tb_imm_gen_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] IR_i;
  logic        valid_i;
  logic        zext_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [1:0]  kind_o;
  logic        valid_o;
  logic        ready_i;
`ifdef IMM_GEN_PIPE_STATS_EN
  logic [15:0] count_o;
`endif

  imm_gen_pipe dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .IR_i    (IR_i),
    .valid_i (valid_i),
    .zext_i  (zext_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .kind_o  (kind_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    .count_o (count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_out   = 0;
  logic [31:0] sb_data[$];
  logic [1:0]  sb_kind[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Offer one word; the expected result is queued at the edge it is accepted.
  task automatic push(input logic [31:0] ir, input logic zx,
                      input logic [31:0] ed, input logic [1:0] ek);
    int k = 0;
    bit done = 1'b0;
    IR_i    = ir;
    zext_i  = zx;
    valid_i = 1'b1;
    while (!done && k < 50) begin
      @(negedge clk_i);
      if (ready_o) begin
        sb_data.push_back(ed);
        sb_kind.push_back(ek);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
      k++;
    end
    valid_i = 1'b0;
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_data.size() != 0 && k < 50) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    chk("drain_empty", 64'(sb_data.size()), 64'd0);
  endtask

  // Monitor: output transfer happens at the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && ready_i) begin
        if (sb_data.size() == 0) begin
          chk("unexpected_output", 64'(data_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("data_o", 64'(data_o), 64'(sb_data.pop_front()));
          chk("kind_o", 64'(kind_o), 64'(sb_kind.pop_front()));
          n_out++;
        end
      end else if (!valid_o) begin
        chk("idle_zero", 64'({kind_o, data_o}), 64'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    zext_i  = 1'b0;
    IR_i    = 32'h0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o",  64'(data_o),  64'd0);
    chk("rst_kind_o",  64'(kind_o),  64'd0);

    // Extraction formats, one-cycle latency, stored value is frozen.
    ready_i = 1'b1;
    push(32'h8800_0001, 1'b0, 32'hF800_0001, 2'b10);
    chk("lat_valid_o", 64'(valid_o), 64'd1);
    IR_i   = 32'hFFFF_FFFF;
    zext_i = 1'b1;
    #1;
    chk("frozen_data_o", 64'(data_o), 64'hF800_0001);
    push(32'h2040_0005, 1'b0, 32'hFFC0_0005, 2'b01);
    push(32'h4002_0003, 1'b0, 32'hFFFE_0003, 2'b00);
    push(32'h4002_0003, 1'b1, 32'h0002_0003, 2'b00);
    push(32'h8800_0001, 1'b1, 32'h0800_0001, 2'b10);
    push(32'h2000_0005, 1'b0, 32'h0000_0005, 2'b01);
    drain();
    chk("deliver_count_a", 64'(n_out), 64'd6);

    // Full FIFO refuses input even while the head is taken.
    ready_i = 1'b0;
    n0 = n_out;
    push(32'h4000_0001, 1'b0, 32'h0000_0001, 2'b00);
    push(32'h4000_0002, 1'b0, 32'h0000_0002, 2'b00);
    chk("full_ready_o", 64'(ready_o), 64'd0);
    chk("full_head",    64'(data_o),  64'h1);
    IR_i    = 32'h4000_0003;
    zext_i  = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    drain();
    repeat (2) @(posedge clk_i);
    #1;
    chk("full_deliver", 64'(n_out - n0), 64'd2);
    chk("empty_valid_o", 64'(valid_o), 64'd0);
    chk("empty_ready_o", 64'(ready_o), 64'd1);

    // Back-to-back push and pop: occupancy holds at one.
    n0 = n_out;
    push(32'h4000_0010, 1'b0, 32'h0000_0010, 2'b00);
    push(32'h8000_0020, 1'b0, 32'h0000_0020, 2'b10);
    push(32'h2000_0030, 1'b0, 32'h0000_0030, 2'b01);
    push(32'h4003_FFFF, 1'b0, 32'hFFFF_FFFF, 2'b00);
    chk("stream_ready_o", 64'(ready_o), 64'd1);
    chk("stream_valid_o", 64'(valid_o), 64'd1);
    drain();
    chk("stream_deliver", 64'(n_out - n0), 64'd4);

    // Reset with a full FIFO and transfers offered on both sides.
    ready_i = 1'b0;
    push(32'h4000_0011, 1'b0, 32'h0000_0011, 2'b00);
    push(32'h4000_0022, 1'b0, 32'h0000_0022, 2'b00);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    IR_i    = 32'h4000_0033;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    sb_data.delete();
    sb_kind.delete();
    n0 = n_out;
    chk("rst2_valid_o", 64'(valid_o), 64'd0);
    chk("rst2_ready_o", 64'(ready_o), 64'd1);
    chk("rst2_data_o",  64'(data_o),  64'd0);
    chk("rst2_kind_o",  64'(kind_o),  64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst2_nothing_out", 64'(n_out - n0), 64'd0);

`ifdef IMM_GEN_PIPE_STATS_EN
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("cnt_reset", 64'(count_o), 64'd0);
    for (int i = 0; i < 3; i++) push(32'h4000_0001, 1'b0, 32'h1, 2'b00);
    drain();
    chk("cnt_three", 64'(count_o), 64'd3);
    for (int i = 0; i < 65532; i++) push(32'h4000_0002, 1'b0, 32'h2, 2'b00);
    drain();
    chk("cnt_max", 64'(count_o), 64'hFFFF);
    push(32'h4000_0003, 1'b0, 32'h3, 2'b00);
    drain();
    chk("cnt_wrap", 64'(count_o), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
